instr_issue_queue: RTL and testbench

In-order instruction issue buffer that feeds the single-instruction `instr` input of the Tomasulo core. It accepts instructions from the fetch side over a valid/ready handshake and stores them in a DEPTH-entry FIFO. It presents one instruction per cycle on a registered output and holds it while the core reports a structural stall for that instruction's class (`A_stall` for arithmetic, `LS_stall` for load/store). When nothing is available it presents an all-zero bubble.

---
 rtl/instr_issue_queue.sv | 156 +++++++++++++++
 tb/tb_instr_issue_queue.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_queue.sv
// -----------------------------------------------------------------------------
// instr_issue_queue
//
// In-order issue buffer in front of a single-instruction Tomasulo core.
// Instructions arrive over a valid/ready handshake, wait in a DEPTH-entry
// circular FIFO, and are presented one at a time on a registered output.
// The output holds while the core stalls the class of the instruction it is
// currently seeing (A_stall for arithmetic, LS_stall for load/store).
// Unsupported opcodes are dropped after one cycle and flagged with
// illegal_pulse. An all-zero word on instr is a bubble.
//
// Ports
//   clk           : single clock, all state updates on the rising edge
//   reset         : synchronous, active-low
//   in_valid      : fetch side presents in_instr
//   in_instr      : 32-bit RV32 instruction word
//   in_ready      : queue can accept (FIFO not full and reset high)
//   A_stall       : core arithmetic reservation stations full
//   LS_stall      : core load/store buffers full
//   instr         : registered instruction to the core, 32'h0 = bubble
//   instr_valid   : instr is not a bubble
//   occupancy     : FIFO entries held, excluding the output register
//   empty         : no FIFO entries and no valid instr
//   issued_count  : instructions accepted by the core, wraps
//   illegal_pulse : one-cycle pulse when an unsupported opcode is dropped
// -----------------------------------------------------------------------------
module instr_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_instr,
  output logic                       in_ready,
  input  logic                       A_stall,
  input  logic                       LS_stall,
  output logic [31:0]                instr,
  output logic                       instr_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       empty,
  output logic [CNT_W-1:0]           issued_count,
  output logic                       illegal_pulse
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // FIFO storage; the output register below acts as its registered read port
  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  logic [31:0]       instr_q, instr_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic              illegal_q, illegal_d;

  logic is_bubble, is_a, is_ls, is_illegal;
  logic consumed, push_ok, fifo_push, fifo_pop;

  // Class decode of the word currently presented to the core
  always_comb begin
    is_bubble  = (instr_q == 32'h0);
    is_a       = (instr_q[6:0] == OP_R) || (instr_q[6:0] == OP_I);
    is_ls      = (instr_q[6:0] == OP_LOAD) || (instr_q[6:0] == OP_STORE);
    is_illegal = !is_bubble && !is_a && !is_ls;
  end

  // Only the stall matching the presented class can hold the register;
  // bubbles and illegal words always leave.
  assign consumed = is_bubble || is_illegal ||
                    (is_a && !A_stall) || (is_ls && !LS_stall);

  assign in_ready = reset && (occ_q != OCC_FULL);
  assign push_ok  = in_valid && in_ready;

  // An empty FIFO with a consuming output lets the incoming word bypass
  // straight into the output register instead of being written.
  assign fifo_pop  = consumed && (occ_q != '0);
  assign fifo_push = push_ok && !(consumed && (occ_q == '0));

  always_comb begin
    instr_d   = instr_q;
    issued_d  = issued_q;
    illegal_d = is_illegal;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    occ_d     = occ_q;

    if (consumed) begin
      if (fifo_pop) begin
        instr_d = mem_q[rd_ptr_q];
      end else if (push_ok) begin
        instr_d = in_instr;
      end else begin
        instr_d = 32'h0;
      end
      if (is_a || is_ls) begin
        issued_d = issued_q + CNT_W'(1);
      end
    end

    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (fifo_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    case ({fifo_push, fifo_pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Storage array carries no reset; pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q] <= in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q   <= 32'h0;
      issued_q  <= '0;
      illegal_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      occ_q     <= '0;
    end else begin
      instr_q   <= instr_d;
      issued_q  <= issued_d;
      illegal_q <= illegal_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      occ_q     <= occ_d;
    end
  end

  assign instr         = instr_q;
  assign instr_valid   = !is_bubble;
  assign occupancy     = occ_q;
  assign empty         = (occ_q == '0) && is_bubble;
  assign issued_count  = issued_q;
  assign illegal_pulse = illegal_q;

endmodule

// File: tb/tb_instr_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_issue_queue
//
// Directed scenarios with literal expectations, a randomized phase, and a
// long counter-wrap stream. A queue-based reference model advances on every
// rising edge; a compare process checks all outputs against it on every
// falling edge.
// -----------------------------------------------------------------------------
module tb_instr_issue_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] LW  = 32'h0040A283;
  localparam logic [31:0] SW  = 32'h0050A423;
  localparam logic [31:0] MUL = 32'h02208233;
  localparam logic [31:0] ILL = 32'h0000007F;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic        A_stall = 1'b0;
  logic        LS_stall = 1'b0;
  logic        in_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic [2:0]  occupancy;
  logic        empty;
  logic [CNT_W-1:0] issued_count;
  logic        illegal_pulse;

  instr_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .A_stall      (A_stall),
    .LS_stall     (LS_stall),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .occupancy    (occupancy),
    .empty        (empty),
    .issued_count (issued_count),
    .illegal_pulse(illegal_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  bit verbose = 1'b1;

  // Reference model state
  logic [31:0]      m_instr = 32'h0;
  logic [31:0]      m_q[$];
  logic [CNT_W-1:0] m_cnt = '0;
  logic             m_pulse = 1'b0;

  // 0 = bubble, 1 = arithmetic, 2 = load/store, 3 = illegal
  function automatic int classify(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    if (w == 32'h0) return 0;
    if (op == 7'b0110011 || op == 7'b0010011) return 1;
    if (op == 7'b0000011 || op == 7'b0100011) return 2;
    return 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  c;
    bit  cons;
    bit  can_push;
    if (!reset) begin
      m_instr = 32'h0;
      m_q.delete();
      m_cnt   = '0;
      m_pulse = 1'b0;
    end else begin
      c        = classify(m_instr);
      cons     = (c == 0) || (c == 3) || (c == 1 && !A_stall) || (c == 2 && !LS_stall);
      can_push = in_valid && (m_q.size() < DEPTH);
      m_pulse  = (c == 3);
      if (cons) begin
        if (c == 1 || c == 2) begin
          m_cnt++;
          if (verbose) $display("issue %h count=%0d", m_instr, m_cnt);
        end
        if (m_q.size() > 0) begin
          m_instr = m_q.pop_front();
          if (can_push) m_q.push_back(in_instr);
        end else begin
          m_instr = can_push ? in_instr : 32'h0;
        end
      end else if (can_push) begin
        m_q.push_back(in_instr);
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("instr", instr, m_instr);
      chk("instr_valid", 32'(instr_valid), 32'(m_instr != 32'h0));
      chk("occupancy", 32'(occupancy), 32'(m_q.size()));
      chk("empty", 32'(empty), 32'(m_q.size() == 0 && m_instr == 32'h0));
      chk("issued_count", 32'(issued_count), 32'(m_cnt));
      chk("illegal_pulse", 32'(illegal_pulse), 32'(m_pulse));
      chk("in_ready", 32'(in_ready), 32'(reset && m_q.size() != DEPTH));
    end
  end

  task automatic drive(input bit v, input logic [31:0] w, input bit a, input bit ls, input bit rst_n);
    in_valid = v;
    in_instr = w;
    A_stall  = a;
    LS_stall = ls;
    reset    = rst_n;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic do_reset();
    drive(0, 32'h0, 0, 0, 0);
    tick();
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    int sel;
    r   = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1:    return {r[31:7], 7'b0110011};
      2, 3:    return {r[31:7], 7'b0010011};
      4, 5:    return {r[31:7], 7'b0000011};
      6:       return {r[31:7], 7'b0100011};
      7:       return {r[31:7], 7'b1111111};
      8:       return 32'h0;
      default: return r;
    endcase
  endfunction

  initial begin
    logic [31:0] w [4];

    // Reset and bypass latency
    do_reset();
    tick();
    cmp_en = 1'b1;
    chk("reset_instr", instr, 32'h0);
    chk("reset_empty", 32'(empty), 32'h1);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    drive(1, ADD, 0, 0, 1);
    tick();
    chk("bypass_instr", instr, ADD);
    chk("bypass_valid", 32'(instr_valid), 32'h1);
    drive(0, 32'h0, 0, 0, 1);
    tick();
    chk("bypass_drain", instr, 32'h0);
    chk("bypass_count", 32'(issued_count), 32'h1);

    // LS stall holds lw while sw and mul queue behind it
    do_reset();
    drive(1, LW, 0, 1, 1);  tick();
    drive(1, SW, 0, 1, 1);  tick();
    drive(1, MUL, 0, 1, 1); tick();
    drive(0, 32'h0, 0, 1, 1); tick();
    chk("ls_hold_instr", instr, LW);
    chk("ls_hold_occ", 32'(occupancy), 32'h2);
    drive(0, 32'h0, 0, 0, 1);
    tick(); chk("ls_order_1", instr, SW);
    tick(); chk("ls_order_2", instr, MUL);
    tick(); chk("ls_order_3", instr, 32'h0);
    chk("ls_count", 32'(issued_count), 32'h3);

    // Fill the FIFO under A_stall, extra push ignored
    do_reset();
    for (int i = 0; i < 4; i++) w[i] = {12'(i + 1), 20'h00013};
    drive(1, ADD, 1, 0, 1); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, w[i], 1, 0, 1);
      tick();
    end
    chk("full_occ", 32'(occupancy), 32'h4);
    chk("full_ready", 32'(in_ready), 32'h0);
    drive(1, MUL, 1, 0, 1); tick();
    chk("full_ignored_occ", 32'(occupancy), 32'h4);
    chk("full_hold", instr, ADD);
    drive(0, 32'h0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_order", instr, w[i]);
    end
    tick();
    chk("full_drain", instr, 32'h0);
    chk("full_count", 32'(issued_count), 32'h5);

    // Illegal word dropped with a pulse
    do_reset();
    drive(1, ILL, 0, 0, 1); tick();
    chk("ill_present", instr, ILL);
    chk("ill_no_pulse_yet", 32'(illegal_pulse), 32'h0);
    drive(1, ADD, 0, 0, 1); tick();
    chk("ill_pulse", 32'(illegal_pulse), 32'h1);
    chk("ill_next", instr, ADD);
    chk("ill_count0", 32'(issued_count), 32'h0);
    drive(0, 32'h0, 0, 0, 1); tick();
    chk("ill_pulse_end", 32'(illegal_pulse), 32'h0);
    chk("ill_count1", 32'(issued_count), 32'h1);

    // Reset mid-operation
    do_reset();
    drive(1, ADD, 1, 0, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, MUL, 1, 0, 1);
      tick();
    end
    chk("mid_occ", 32'(occupancy), 32'h3);
    drive(0, 32'h0, 1, 0, 0); tick();
    chk("mid_instr", instr, 32'h0);
    chk("mid_occ0", 32'(occupancy), 32'h0);
    chk("mid_count", 32'(issued_count), 32'h0);
    chk("mid_empty", 32'(empty), 32'h1);
    chk("mid_ready", 32'(in_ready), 32'h0);
    drive(1, ADD, 0, 0, 1); tick();
    chk("mid_after", instr, ADD);
    drive(0, 32'h0, 0, 0, 1); tick();
    chk("mid_after_count", 32'(issued_count), 32'h1);

    // Randomized traffic
    verbose = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 9) < 7), rand_word(),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 99) != 0));
      tick();
    end

    // Counter wrap with back-to-back issue
    do_reset();
    for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
      drive(1, {i[11:0], 20'h00013}, 0, 0, 1);
      tick();
      chk("stream_valid", 32'(instr_valid), 32'h1);
    end
    drive(0, 32'h0, 0, 0, 1);
    tick();
    chk("wrap_count", 32'(issued_count), 32'h2);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
